rr_res_arb: RTL and testbench



---
 rtl/rr_res_arb_pkg.sv | 22 ++
 rtl/rr_res_arb_pick.sv | 79 +++++++
 rtl/rr_res_arb.sv | 180 ++++++++++++++++++
 tb/tb_rr_res_arb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_res_arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//
// Shared definitions for the round-robin resource arbiter (rr_res_arb) and
// its combinational winner picker (rr_pick).
//
// Contents:
//   state_t      FSM state encoding (IDLE=0, BUSY=1)
//   IDX_W        width of every requester index (gnt_id, last, picker index)
//   DEF_TIMEOUT  default watchdog limit in cycles
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int IDX_W       = 8;
    localparam int DEF_TIMEOUT = 255;

endpackage : arb_pkg

// File: rtl/rr_res_arb_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin winner selection.
// The request vector is rotated so that index last+1 lands at bit 0.
// A lowest-set-bit search then runs on the rotated vector.
// The result is un-rotated back into the requester index space.
//
// Parameters:
//   N         number of requesters (2..16)
// Ports:
//   i_req     [N]      request levels
//   i_last    [IDX_W]  index of the most recently served requester
//   o_onehot  [N]      one-hot winner, all-zero when no request
//   o_idx     [IDX_W]  binary winner index, 0 when no request
//   o_any     1        at least one request pending
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_start;    // first index searched
    logic [2*N-1:0]   w_dbl;      // doubled request vector, shifted
    logic [N-1:0]     w_rot;      // requests rotated so w_start is bit 0
    logic [IDX_W-1:0] w_off;      // winner offset within rotated vector
    logic [IDX_W-1:0] w_sum;      // un-rotated index before modulo wrap
    logic [IDX_W-1:0] w_idx;      // wrapped winner index
    logic             w_unused_hi;

    // Wrap explicitly: the search after N-1 starts at 0.
    assign w_start = (i_last >= IDX_W'(N - 1)) ? '0 : i_last + 1'b1;

    // Rotate right by w_start.
    // Shifting a doubled copy brings the wrapped-around bits into the low half.
    assign w_dbl = {i_req, i_req} >> w_start;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign w_rot[gi] = w_dbl[gi];
        end
    endgenerate

    // Only the low half of the shifted copy is meaningful.
    assign w_unused_hi = ^w_dbl[2*N-1:N];

    // Lowest set bit wins.
    // Scanning downward lets the last hit, which is the lowest bit, stick.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    // Un-rotate: offset + start, reduced modulo N.
    // Both operands are < N, so a single subtraction is enough.
    assign w_sum = w_off + w_start;
    assign w_idx = (w_sum >= IDX_W'(N)) ? w_sum - IDX_W'(N) : w_sum;

    assign o_any = |i_req;
    assign o_idx = o_any ? w_idx : '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign o_onehot[gi] = o_any && (w_idx == IDX_W'(gi));
        end
    endgenerate

endmodule : rr_pick

// File: rtl/rr_res_arb.sv
// ---------------------------------------------------------------------------
// rr_res_arb
//
// Round-robin arbiter sharing a single multi-cycle compute resource among N
// requesters.
//
// Operation:
//   IDLE  A pending requester is picked in round-robin order.
//         The grant is registered and res_start is pulsed.
//   BUSY  The grant is held until res_done.
//   On res_done the winner is acknowledged, the grant is cleared, priority
//   rotates, and the FSM returns to IDLE.
//
// Optional feature, enabled by compiling with RR_RES_ARB_TIMEOUT_EN defined:
//   A 16-bit watchdog counts BUSY cycles. When the count reaches TIMEOUT
//   without res_done, the run is aborted: err is pulsed instead of ack.
//   Without the macro there is no counter and err is tied to 0.
//
// Parameters:
//   N          number of requesters (2..16)
//   TIMEOUT    watchdog limit in cycles (1..65535), used only with the watchdog
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   req        [N]  request levels, held by each requester until its ack
//   gnt        [N]  registered one-hot grant, zero when idle
//   gnt_id     [8]  registered binary index of the grant, zero when idle
//   ack        [N]  one-cycle completion pulse to the served requester
//   res_start  1    one-cycle pulse launching the resource
//   res_done   1    one-cycle completion pulse from the resource
//   err        1    one-cycle watchdog abort pulse
// ---------------------------------------------------------------------------
module rr_res_arb
    import arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic [N-1:0]     ack,
    output logic             res_start,
    input  logic             res_done,
    output logic             err
);

    state_t           r_state;
    logic [IDX_W-1:0] r_last;     // most recently served (or aborted) index
    logic [N-1:0]     r_gnt;
    logic [IDX_W-1:0] r_gnt_id;
    logic [N-1:0]     r_ack;
    logic             r_start;

    logic [N-1:0]     w_pick_onehot;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;

    rr_pick #(
        .N (N)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

`ifdef RR_RES_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;           // BUSY cycles already elapsed before this edge
    logic        r_err;
    logic        w_expire;

    // At a BUSY edge, r_cnt + 1 is the number of BUSY cycles completed.
    // The run expires on the edge that completes the TIMEOUT-th cycle.
    assign w_expire = (r_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= IDX_W'(N - 1);
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ack    <= '0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // Pulse outputs default low and are raised for a single cycle.
            r_ack   <= '0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt    <= w_pick_onehot;
                        r_gnt_id <= w_pick_idx;
                        r_start  <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    // res_done is tested first, so it wins over a timeout
                    // that expires on the same edge.
                    if (res_done) begin
                        r_ack    <= r_gnt;
                        r_last   <= r_gnt_id;
                        r_gnt    <= '0;
                        r_gnt_id <= '0;
                        r_state  <= IDLE;
                    end else if (w_expire) begin
                        r_err    <= 1'b1;
                        r_last   <= r_gnt_id;
                        r_gnt    <= '0;
                        r_gnt_id <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign err = r_err;
`else
    logic w_unused_cfg;

    // The watchdog limit has no effect in this build.
    assign w_unused_cfg = (TIMEOUT != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= IDX_W'(N - 1);
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ack    <= '0;
            r_start  <= 1'b0;
        end else begin
            r_ack   <= '0;
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt    <= w_pick_onehot;
                        r_gnt_id <= w_pick_idx;
                        r_start  <= 1'b1;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    // Requests are deliberately ignored here; only res_done
                    // ends the run.
                    if (res_done) begin
                        r_ack    <= r_gnt;
                        r_last   <= r_gnt_id;
                        r_gnt    <= '0;
                        r_gnt_id <= '0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign err = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign ack       = r_ack;
    assign res_start = r_start;

endmodule : rr_res_arb

// File: tb/tb_rr_res_arb.sv
// ---------------------------------------------------------------------------
// tb_rr_res_arb
//
// Directed test of rr_res_arb with N=4 and TIMEOUT=8.
// The stimulus process queues the expected grant and completion for each
// transaction. A monitor pops and compares them whenever the DUT pulses
// res_start, ack or err.
// The watchdog scenarios follow RR_RES_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_rr_res_arb;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         res_done = 1'b0;
    logic [N-1:0] gnt;
    logic [7:0]   gnt_id;
    logic [N-1:0] ack;
    logic         res_start;
    logic         err;

    typedef struct {
        bit is_err;
        int id;
    } end_t;

    int   gnt_q[$];
    end_t end_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    rr_res_arb #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .ack       (ack),
        .res_start (res_start),
        .res_done  (res_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every grant and every completion against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_start) begin
                if (gnt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start: gnt=%b gnt_id=%0d, expected no start", gnt, gnt_id);
                end else begin
                    int e;
                    e = gnt_q.pop_front();
                    chk("gnt_id", 32'(gnt_id), e);
                    chk("gnt_onehot", 32'(gnt), 32'(1) << e);
                    $display("grant   : gnt=%b gnt_id=%0d (expected id %0d)", gnt, gnt_id, e);
                end
            end
            if (ack != '0 || err) begin
                if (end_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_end: ack=%b err=%b, expected none", ack, err);
                end else begin
                    end_t x;
                    x = end_q.pop_front();
                    chk("end_ack", 32'(ack), x.is_err ? 32'd0 : (32'(1) << x.id));
                    chk("end_err", 32'(err), 32'(x.is_err));
                    chk("end_gnt_clear", 32'(gnt), 0);
                    chk("end_gnt_id_clear", 32'(gnt_id), 0);
                    $display("complete: ack=%b err=%b gnt=%b (expected %s for id %0d)",
                             ack, err, gnt, x.is_err ? "err" : "ack", x.id);
                end
            end
        end
    end

    // Present a request and wait (bounded) for its grant.
    // The expected latency is one cycle from a negedge at which the DUT is idle.
    task automatic grant(input logic [N-1:0] rv, input int exp_id);
        int k;
        req = rv;
        gnt_q.push_back(exp_id);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (res_start) break;
        end
        chk("grant_latency", 32'(k), 1);
    endtask

    // Pulse res_done so that it is sampled delay cycles after the start edge.
    // Then wait (bounded) for the ack.
    task automatic complete(input int delay, input int exp_id, input bit drop_req);
        int k;
        end_t x;
        repeat (delay - 1) @(negedge clk);
        res_done = 1'b1;
        x.is_err = 1'b0;
        x.id = exp_id;
        end_q.push_back(x);
        @(negedge clk);
        res_done = 1'b0;
        for (k = 0; k < 10; k++) begin
            if (ack != '0) break;
            @(negedge clk);
        end
        chk("ack_latency", 32'(k), 0);
        if (drop_req) req = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        static int rot_ids[5] = '{0, 1, 2, 3, 0};

        // Reset values
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_gnt_id", 32'(gnt_id), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_start", 32'(res_start), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;

        // Single request from reset; done five cycles after start
        grant(4'b0001, 0);
        complete(5, 0, 1'b1);

        // Rotation with all requests held; fresh reset so the order starts at 0
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            grant(4'b1111, rot_ids[i]);
            complete(3, rot_ids[i], i == 4);
        end

        // Wrap and skip: after index 2, request 0011 goes to 0
        grant(4'b0100, 2);
        complete(2, 2, 1'b0);
        grant(4'b0011, 0);
        complete(2, 0, 1'b1);

        // Mid-BUSY request changes are ignored
        grant(4'b0010, 1);
        req = 4'b1000;
        repeat (3) begin
            @(negedge clk);
            chk("hold_gnt", 32'(gnt), 32'b0010);
            chk("hold_gnt_id", 32'(gnt_id), 1);
        end
        complete(2, 1, 1'b1);

        // res_done while idle does nothing
        @(negedge clk);
        res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_done_gnt", 32'(gnt), 0);
            chk("idle_done_start", 32'(res_start), 0);
            chk("idle_done_ack", 32'(ack), 0);
        end
        grant(4'b1111, 2);
        complete(2, 2, 1'b1);

        // Asynchronous reset in the middle of a BUSY run
        grant(4'b0001, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_gnt_id", 32'(gnt_id), 0);
        chk("arst_ack", 32'(ack), 0);
        chk("arst_start", 32'(res_start), 0);
        chk("arst_err", 32'(err), 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        res_done = 1'b1;            // stale completion from the aborted run
        @(negedge clk);
        res_done = 1'b0;
        @(negedge clk);
        chk("stale_done_ack", 32'(ack), 0);
        chk("stale_done_gnt", 32'(gnt), 0);
        grant(4'b1000, 3);
        complete(3, 3, 1'b1);

`ifdef RR_RES_ARB_TIMEOUT_EN
        // Watchdog expiry: err arrives TIMEOUT cycles after the start pulse
        begin
            int   k;
            end_t x;
            grant(4'b0001, 0);
            x.is_err = 1'b1;
            x.id = 0;
            end_q.push_back(x);
            for (k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (err) break;
            end
            chk("timeout_cycles", 32'(k), TIMEOUT);
            req = '0;
        end
        // res_done on the expiry cycle wins
        grant(4'b0010, 1);
        complete(TIMEOUT, 1, 1'b1);
`else
        // Without the watchdog a long stall keeps the grant and never errs
        begin
            int bad;
            bad = 0;
            grant(4'b0001, 0);
            repeat (100) begin
                @(negedge clk);
                if (gnt != 4'b0001 || err) bad++;
            end
            chk("stall_hold_bad_cycles", 32'(bad), 0);
            complete(1, 0, 1'b1);
        end
`endif

        repeat (3) @(negedge clk);
        chk("gnt_queue_empty", 32'(gnt_q.size()), 0);
        chk("end_queue_empty", 32'(end_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "global timeout");
    end

endmodule : tb_rr_res_arb
